// File: rtl/idivmod_requester_if.sv
// Bundle of the request stream, result stream and divider-side signals of
// the divide/modulo requester. The master modport is the requester's view;
// the slave modport is the view of whatever surrounds it (producer,
// consumer and the divider itself).
interface idivmod_requester_if #(
  parameter int TAG_W = 4
) ();

  // request stream
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_dividend;
  logic [31:0]      in_divisor;
  logic [TAG_W-1:0] in_tag;

  // result stream
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_quot;
  logic [31:0]      out_rem;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  // divider side
  logic             div_rq;
  logic [31:0]      div_dividend;
  logic [31:0]      div_divisor;
  logic [31:0]      div_quot;
  logic [31:0]      div_rem;
  logic             div_ack;
  logic             div_hung;

  modport master (
    input  in_valid, in_dividend, in_divisor, in_tag,
    output in_ready,
    output out_valid, out_quot, out_rem, out_tag, out_err,
    input  out_ready,
    output div_rq, div_dividend, div_divisor, div_hung,
    input  div_quot, div_rem, div_ack
  );

  modport slave (
    output in_valid, in_dividend, in_divisor, in_tag,
    input  in_ready,
    input  out_valid, out_quot, out_rem, out_tag, out_err,
    output out_ready,
    input  div_rq, div_dividend, div_divisor, div_hung,
    output div_quot, div_rem, div_ack
  );

endinterface

// File: rtl/idivmod_requester.sv
// Initiator-side front end for the multi-cycle signed divide/modulo unit.
// Requests are queued in a small in-order FIFO, issued to the divider with a
// one-cycle rq pulse, and answered on a registered valid/ready result port.
// Divide-by-zero never reaches the divider, and a watchdog turns a divider
// that stops acking into a sticky "hung" condition answered locally.
module idivmod_requester #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                reset,
  idivmod_requester_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  // The watchdog fires in the cycle whose increment would reach TIMEOUT,
  // so a request waits exactly TIMEOUT cycles in WAIT_LOW/WAIT_ACK.
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_ACK,
    RESP
  } state_t;

  typedef struct packed {
    logic [31:0]      dividend;
    logic [31:0]      divisor;
    logic [TAG_W-1:0] tag;
  } req_t;

  // ---------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------
  req_t             fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             in_ready_w;
  req_t             in_entry;
  req_t             head;

  // Full is judged on the registered count only: a pop in the same cycle
  // does not make room for a push.
  assign in_ready_w = reset & (count_q != FULL_CNT);
  assign fifo_push  = bus.in_valid & in_ready_w;
  assign fifo_empty = (count_q == '0);
  assign in_entry   = '{dividend: bus.in_dividend,
                        divisor:  bus.in_divisor,
                        tag:      bus.in_tag};
  assign head       = fifo_mem[rd_ptr_q];

  // FIFO storage write port; contents need no reset because the
  // pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q] <= in_entry;
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Request sequencer
  // ---------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [31:0]      op_dividend_q, op_dividend_d;
  logic [31:0]      op_divisor_q,  op_divisor_d;
  logic [TAG_W-1:0] op_tag_q,      op_tag_d;
  logic [31:0]      res_quot_q,    res_quot_d;
  logic [31:0]      res_rem_q,     res_rem_d;
  logic             res_err_q,     res_err_d;
  logic [WD_W-1:0]  wd_cnt_q,      wd_cnt_d;
  logic             hung_q,        hung_d;
  logic             out_valid_q,   out_valid_d;
  logic [31:0]      out_quot_q,    out_quot_d;
  logic [31:0]      out_rem_q,     out_rem_d;
  logic [TAG_W-1:0] out_tag_q,     out_tag_d;
  logic             out_err_q,     out_err_d;

  // Next-state, datapath loads and result-register update.
  always_comb begin
    state_d       = state_q;
    fifo_pop      = 1'b0;
    op_dividend_d = op_dividend_q;
    op_divisor_d  = op_divisor_q;
    op_tag_d      = op_tag_q;
    res_quot_d    = res_quot_q;
    res_rem_d     = res_rem_q;
    res_err_d     = res_err_q;
    wd_cnt_d      = wd_cnt_q;
    hung_d        = hung_q;
    // A consumed result drops valid unless RESP reloads on the same edge.
    out_valid_d   = out_valid_q & ~bus.out_ready;
    out_quot_d    = out_quot_q;
    out_rem_d     = out_rem_q;
    out_tag_d     = out_tag_q;
    out_err_d     = out_err_q;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          op_dividend_d = head.dividend;
          op_divisor_d  = head.divisor;
          op_tag_d      = head.tag;
          if (head.divisor == '0) begin
            // The divider would never terminate; answer locally.
            res_quot_d = '1;
            res_rem_d  = head.dividend;
            res_err_d  = 1'b1;
            state_d    = RESP;
          end else if (hung_q) begin
            // Divider is considered dead: never issue again.
            res_quot_d = '0;
            res_rem_d  = '0;
            res_err_d  = 1'b1;
            state_d    = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        wd_cnt_d = '0;
        state_d  = WAIT_LOW;
      end

      WAIT_LOW: begin
        // An ack still high here belongs to the previous operation; only
        // its fall proves the divider accepted this request.
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (wd_cnt_q == WD_LAST) begin
          res_quot_d = '0;
          res_rem_d  = '0;
          res_err_d  = 1'b1;
          hung_d     = 1'b1;
          state_d    = RESP;
        end else if (!bus.div_ack) begin
          state_d = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (bus.div_ack) begin
          res_quot_d = bus.div_quot;
          res_rem_d  = bus.div_rem;
          res_err_d  = 1'b0;
          state_d    = RESP;
        end else if (wd_cnt_q == WD_LAST) begin
          res_quot_d = '0;
          res_rem_d  = '0;
          res_err_d  = 1'b1;
          hung_d     = 1'b1;
          state_d    = RESP;
        end
      end

      RESP: begin
        if (!out_valid_q || bus.out_ready) begin
          out_valid_d = 1'b1;
          out_quot_d  = res_quot_q;
          out_rem_d   = res_rem_q;
          out_tag_d   = op_tag_q;
          out_err_d   = res_err_q;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, pending-result, watchdog and sticky-hung registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_dividend_q <= '0;
      op_divisor_q  <= '0;
      op_tag_q      <= '0;
      res_quot_q    <= '0;
      res_rem_q     <= '0;
      res_err_q     <= 1'b0;
      wd_cnt_q      <= '0;
      hung_q        <= 1'b0;
    end else begin
      op_dividend_q <= op_dividend_d;
      op_divisor_q  <= op_divisor_d;
      op_tag_q      <= op_tag_d;
      res_quot_q    <= res_quot_d;
      res_rem_q     <= res_rem_d;
      res_err_q     <= res_err_d;
      wd_cnt_q      <= wd_cnt_d;
      hung_q        <= hung_d;
    end
  end

  // Result output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_quot_q  <= '0;
      out_rem_q   <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_quot_q  <= out_quot_d;
      out_rem_q   <= out_rem_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Port drive
  // ---------------------------------------------------------------------
  // Operands come straight from the operand registers, which only change
  // on a pop in IDLE, so they are stable while the divider works.
  assign bus.in_ready     = in_ready_w;
  assign bus.div_rq       = (state_q == ISSUE);
  assign bus.div_dividend = op_dividend_q;
  assign bus.div_divisor  = op_divisor_q;
  assign bus.div_hung     = hung_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_quot     = out_quot_q;
  assign bus.out_rem      = out_rem_q;
  assign bus.out_tag      = out_tag_q;
  assign bus.out_err      = out_err_q;

endmodule
